bsg_receiver: RTL and testbench
===============================

# bsg_receiver

Receive-side counterpart of the binary signal generator, sitting directly downstream of its modulated 8-bit symbol output. It captures Gray-coded symbols, decodes them back to binary, pairs consecutive symbols into {DATA_1, DATA_0} words, and buffers them in a small FIFO. Software drains the FIFO through the same 8-bit register-bus style (addr / Data_in / Data_out, valid / ready) used by the transmitter. An optional maskable interrupt signals data arrival or overrun.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in byte pairs; power of two, 2..16.

Ports:
- SYS_CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN  input  8  Gray-coded symbol from the transmit path, already synchronised to SYS_CLK.
- IN_VALID  input  1  one-cycle strobe per symbol; IN is valid only when IN_VALID=1.
- RX_INT  output  1  interrupt, equal to INTFLAG & INTMSK.
- Data_in  input  8  bus write data.
- addr  input  8  bus register address.
- write  input  1  bus direction: 1=write, 0=read; sampled with valid.
- valid  input  1  bus request; held high by the master until it sees ready.
- Data_out  output  8  bus read data; meaningful while ready=1.
- ready  output  1  bus acknowledge, one-cycle pulse.

## Operation
- Registers:
  - 0x00 CONTROL:
    - bit0 RXENABLE (rw).
    - bit1 INTMSK (rw; 1 = interrupt enabled).
    - bit2 INTFLAG (read; write-1-to-clear).
    - bit3 NONEMPTY (ro).
    - bit4 OVERRUN (read; write-1-to-clear).
    - bits7:5 read 0.
  - 0x01 DATA_0: low byte of FIFO head; read does not pop.
  - 0x02 DATA_1: high byte of FIFO head; read pops.
  - 0x03 LEVEL: number of stored pairs, 0..DEPTH.
  - Other addresses: read 0x00, writes ignored.
- Gray decode: b[7]=g[7]; b[i]=b[i+1]^g[i] for i=6..0.
- Symbol pairing:
  - A HALF bit (reset 0) selects the slot. On IN_VALID with RXENABLE=1 and HALF=0, the decoded byte is stored in the staging register and HALF becomes 1.
  - With HALF=1, {decoded, staging} is pushed into the FIFO and HALF becomes 0.
  - IN_VALID with RXENABLE=0 is ignored.
  - Clearing RXENABLE forces HALF=0 and discards the staged byte.
- FIFO: circular buffer with read/write pointers wrapping modulo DEPTH and a count 0..DEPTH.
  - Push when full with no pop in the same cycle: the pair is dropped, OVERRUN and INTFLAG are set.
  - Push and pop in the same cycle when full: both happen and there is no overrun.
  - Push and pop in the same cycle when empty: not possible, since a pop requires a nonempty FIFO.
- Reads of DATA_0/DATA_1 when empty return 0x00 and do not pop.
- INTFLAG is set on a push into an empty FIFO, or on overrun. A set event in the same cycle as a W1C clear wins.
- Bus FSM:
  - IDLE: on valid=1, perform the access (register write or read-capture, including pop) and go to ACK.
  - ACK: ready=1 and Data_out holds the captured value; go to WAIT.
  - WAIT: stay until valid=0, then go to IDLE. This guarantees exactly one access per request.
- Reset (asynchronous, RST_N=0):
  - FSM=IDLE.
  - All registers, pointers, count, HALF and staging cleared.
  - Data_out=0x00, ready=0, RX_INT=0.
  - Reset asserted mid-transaction aborts it; ready stays 0.

## Timing
- Symbol path: IN_VALID at edge t latches staging or pushes at edge t. LEVEL, NONEMPTY and INTFLAG reflect the push from cycle t+1.
- RX_INT is combinational from registers, so it rises in the same cycle INTFLAG becomes 1.
- Bus: valid seen in IDLE at edge t → ready=1 during cycle t+1 → earliest next access is 2 cycles after valid falls.
- A pop commits at the IDLE edge where the read is captured. Simultaneous symbol pushes use the pre-pop count plus the full-with-pop rule above.
- Register writes take effect at the IDLE capture edge.

## Test plan
- Basic receive:
  - Stimulus: enable (write 0x00=0x03); strobe IN=Gray(0x5A)=0x77, then IN=Gray(0xC3)=0xA2.
  - Response: LEVEL=1; RX_INT=1; read 0x01→0x5A; read 0x02→0xC3; then LEVEL=0, NONEMPTY=0.
- Disabled / abort:
  - Stimulus: RXENABLE=0, send 2 symbols → LEVEL stays 0. Enable, send 1 symbol, clear RXENABLE, re-enable, send 2 symbols.
  - Response: the FIFO holds only the last pair.
- Overrun, DEPTH=4:
  - Stimulus: push 5 pairs without reads.
  - Response: LEVEL=4, OVERRUN=1, FIFO holds pairs 1-4 in order; writing 0x14 to 0x00 clears OVERRUN and INTFLAG.
- Full with simultaneous pop:
  - Stimulus: FIFO full, a read of 0x02 captured in the same cycle as a second-symbol push.
  - Response: no overrun, LEVEL stays 4, pointer wrap-around correct over 3 full cycles of traffic.
- Handshake:
  - Stimulus: hold valid high for 6 cycles on a 0x02 read.
  - Response: exactly one ready pulse and one pop; reading an empty FIFO returns 0x00.
- Reset:
  - Stimulus: assert RST_N=0 mid-ACK with data buffered.
  - Response: outputs 0 immediately, LEVEL=0 after release, first post-reset access works.

Source files
------------

// File: rtl/bsg_receiver.sv
// rtl/bsg_receiver.sv - Gray-symbol receiver: decode, pair into 16-bit words, FIFO, bus-drained.
module bsg_receiver #(
    parameter int DEPTH = 4
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] IN,
    input  logic       IN_VALID,
    output logic       RX_INT,
    input  logic [7:0] Data_in,
    input  logic [7:0] addr,
    input  logic       write,
    input  logic       valid,
    output logic [7:0] Data_out,
    output logic       ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state;
    logic          rxenable;
    logic          intmsk;
    logic          intflag;
    logic          overrun;
    logic          half;
    logic [7:0]    staging;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   mem [DEPTH];

    logic [7:0]  decoded;
    logic [7:0]  rd_data;
    logic [15:0] head;
    logic        bus_fire;
    logic        ctrl_wr;
    logic        nonempty;
    logic        full;
    logic        pop;
    logic        sym_fire;
    logic        push_req;
    logic        do_push;
    logic        ovr_evt;
    logic        unused_data_in_bits;

    assign unused_data_in_bits = ^{Data_in[7:5], Data_in[3]};

    always_comb begin
        decoded    = 8'h00;
        decoded[7] = IN[7];
        for (int i = 6; i >= 0; i--) begin
            decoded[i] = decoded[i+1] ^ IN[i];
        end
    end

    assign bus_fire = (state == ST_IDLE) && valid;
    assign ctrl_wr  = bus_fire && write && (addr == 8'h00);
    assign nonempty = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = bus_fire && !write && (addr == 8'h02) && nonempty;
    assign sym_fire = IN_VALID && rxenable;
    assign push_req = sym_fire && half;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push  = push_req && (!full || pop);
    assign ovr_evt  = push_req && full && !pop;
    assign head     = mem[rd_ptr];

    assign RX_INT = intflag & intmsk;
    assign ready  = (state == ST_ACK);

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            8'h00: rd_data = {3'b000, overrun, nonempty, intflag, intmsk, rxenable};
            8'h01: rd_data = nonempty ? head[7:0] : 8'h00;
            8'h02: rd_data = nonempty ? head[15:8] : 8'h00;
            8'h03: rd_data = {{(8-CW){1'b0}}, count};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            Data_out <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: if (valid) begin
                    state    <= ST_ACK;
                    Data_out <= write ? 8'h00 : rd_data;
                end
                ST_ACK:  state <= ST_WAIT;
                ST_WAIT: if (!valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxenable <= 1'b0;
            intmsk   <= 1'b0;
            intflag  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rxenable <= Data_in[0];
                intmsk   <= Data_in[1];
            end
            // Set events take priority over a simultaneous write-1-to-clear.
            if ((do_push && !nonempty) || ovr_evt) begin
                intflag <= 1'b1;
            end else if (ctrl_wr && Data_in[2]) begin
                intflag <= 1'b0;
            end
            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && Data_in[4]) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            half    <= 1'b0;
            staging <= 8'h00;
        end else if (!rxenable || (ctrl_wr && !Data_in[0])) begin
            half    <= 1'b0;
            staging <= 8'h00;
        end else if (sym_fire) begin
            if (!half) begin
                staging <= decoded;
            end
            half <= !half;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty-FIFO reads are forced to zero.
    always_ff @(posedge SYS_CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= {decoded, staging};
        end
    end

endmodule

// File: tb/tb_bsg_receiver.sv
// tb/tb_bsg_receiver.sv - Randomized self-checking bench for bsg_receiver against a queue model.
module tb_bsg_receiver;

    localparam int DEPTH = 4;

    logic       SYS_CLK = 1'b0;
    logic       RST_N;
    logic [7:0] IN;
    logic       IN_VALID;
    logic       RX_INT;
    logic [7:0] Data_in;
    logic [7:0] addr;
    logic       write;
    logic       valid;
    logic [7:0] Data_out;
    logic       ready;

    bsg_receiver #(.DEPTH(DEPTH)) dut (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .IN      (IN),
        .IN_VALID(IN_VALID),
        .RX_INT  (RX_INT),
        .Data_in (Data_in),
        .addr    (addr),
        .write   (write),
        .valid   (valid),
        .Data_out(Data_out),
        .ready   (ready)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mq[$];
    bit          m_rxen, m_msk, m_flag, m_ovr, m_half;
    logic [7:0]  m_stg;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_rxen = 0; m_msk = 0; m_flag = 0; m_ovr = 0; m_half = 0; m_stg = 8'h00;
    endtask

    task automatic m_symbol(input logic [7:0] b);
        if (m_rxen) begin
            if (!m_half) begin
                m_stg  = b;
                m_half = 1;
            end else begin
                m_half = 0;
                if (mq.size() == DEPTH) begin
                    m_ovr  = 1;
                    m_flag = 1;
                end else begin
                    if (mq.size() == 0) m_flag = 1;
                    mq.push_back({b, m_stg});
                end
            end
        end
    endtask

    task automatic m_ctrl_write(input logic [7:0] d);
        m_rxen = d[0];
        m_msk  = d[1];
        if (d[2]) m_flag = 0;
        if (d[4]) m_ovr = 0;
        if (!m_rxen) m_half = 0;
    endtask

    task automatic m_read(input logic [7:0] a, output logic [7:0] exp);
        exp = 8'h00;
        if (a == 8'h00) exp = {3'b000, m_ovr, mq.size() != 0, m_flag, m_msk, m_rxen};
        else if (a == 8'h01 && mq.size() != 0) exp = mq[0][7:0];
        else if (a == 8'h02 && mq.size() != 0) begin
            exp = mq[0][15:8];
            void'(mq.pop_front());
        end else if (a == 8'h03) exp = 8'(mq.size());
    endtask

    task automatic bus(input logic [7:0] a, input logic w, input logic [7:0] d, output logic [7:0] q);
        int k;
        addr = a; write = w; Data_in = d; valid = 1'b1; q = 8'h00;
        for (k = 0; k < 10; k++) begin
            @(posedge SYS_CLK); #1;
            if (ready) break;
        end
        if (k == 10) chk("bus_timeout", 16'd0, 16'd1);
        else q = Data_out;
        valid = 1'b0;
        @(posedge SYS_CLK);
        @(posedge SYS_CLK); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(a, 1'b1, d, q);
        if (a == 8'h00) m_ctrl_write(d);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a);
        logic [7:0] q, e;
        m_read(a, e);
        bus(a, 1'b0, 8'h00, q);
        chk(tag, q, e);
    endtask

    task automatic send(input logic [7:0] b);
        IN = gray(b); IN_VALID = 1'b1;
        @(posedge SYS_CLK); #1;
        IN_VALID = 1'b0;
        m_symbol(b);
    endtask

    task automatic int_chk(input string tag);
        chk(tag, RX_INT, m_flag & m_msk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q, e, b, d;
        int pulses;
        RST_N = 1'b0; IN = 8'h00; IN_VALID = 1'b0;
        Data_in = 8'h00; addr = 8'h00; write = 1'b0; valid = 1'b0;
        m_reset();
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK); RST_N = 1'b1;
        @(posedge SYS_CLK); #1;

        chk("reset_ready", ready, 1'b0);
        chk("reset_dout", Data_out, 8'h00);
        chk("reset_int", RX_INT, 1'b0);
        rd_chk("reset_ctrl", 8'h00);
        rd_chk("reset_level", 8'h03);

        // Basic receive
        wr(8'h00, 8'h03);
        chk("gray_5a", gray(8'h5A), 8'h77);
        chk("gray_c3", gray(8'hC3), 8'hA2);
        send(8'h5A); send(8'hC3);
        bus(8'h03, 1'b0, 8'h00, q); chk("basic_level", q, 8'h01);
        chk("basic_int", RX_INT, 1'b1);
        bus(8'h01, 1'b0, 8'h00, q); chk("basic_d0", q, 8'h5A);
        m_read(8'h01, e);
        bus(8'h02, 1'b0, 8'h00, q); chk("basic_d1", q, 8'hC3);
        m_read(8'h02, e);
        bus(8'h03, 1'b0, 8'h00, q); chk("basic_level0", q, 8'h00);
        rd_chk("basic_ctrl", 8'h00);
        wr(8'h00, 8'h07);
        int_chk("basic_int_clr");

        // Disabled / abort
        wr(8'h00, 8'h02);
        send(8'h11); send(8'h22);
        rd_chk("dis_level", 8'h03);
        wr(8'h00, 8'h03);
        send(8'h33);
        wr(8'h00, 8'h02);
        wr(8'h00, 8'h03);
        send(8'h44); send(8'h55);
        rd_chk("abort_level", 8'h03);
        rd_chk("abort_d0", 8'h01);
        rd_chk("abort_d1", 8'h02);
        rd_chk("abort_level0", 8'h03);

        // Overrun
        for (int i = 0; i < 5; i++) begin
            send(8'(i * 16 + 1)); send(8'(i * 16 + 2));
        end
        bus(8'h03, 1'b0, 8'h00, q); chk("ovr_level", q, 8'h04);
        rd_chk("ovr_ctrl", 8'h00);
        int_chk("ovr_int");
        wr(8'h00, 8'h14);
        rd_chk("ovr_clr_ctrl", 8'h00);
        for (int i = 0; i < 4; i++) begin
            rd_chk("ovr_d0", 8'h01);
            rd_chk("ovr_d1", 8'h02);
        end
        wr(8'h00, 8'h03);

        // Full with simultaneous pop, three full trips of the ring
        while (mq.size() < DEPTH) begin
            send(8'($urandom)); send(8'($urandom));
        end
        for (int it = 0; it < 3 * DEPTH; it++) begin
            send(8'($urandom));
            b = 8'($urandom);
            m_read(8'h02, e);
            m_symbol(b);
            IN = gray(b); IN_VALID = 1'b1;
            addr = 8'h02; write = 1'b0; valid = 1'b1;
            @(posedge SYS_CLK); #1;
            IN_VALID = 1'b0;
            chk("sim_ready", ready, 1'b1);
            chk("sim_data", Data_out, e);
            valid = 1'b0;
            @(posedge SYS_CLK);
            @(posedge SYS_CLK); #1;
            rd_chk("sim_level", 8'h03);
            rd_chk("sim_ctrl", 8'h00);
        end
        while (mq.size() > 1) rd_chk("sim_drain", 8'h02);

        // Handshake: valid held 6 cycles yields exactly one access
        pulses = 0;
        m_read(8'h02, e);
        addr = 8'h02; write = 1'b0; valid = 1'b1;
        q = 8'h00;
        repeat (6) begin
            @(posedge SYS_CLK); #1;
            if (ready) begin
                pulses++;
                q = Data_out;
            end
        end
        valid = 1'b0;
        @(posedge SYS_CLK);
        @(posedge SYS_CLK); #1;
        chk("hs_pulses", 16'(pulses), 16'd1);
        chk("hs_data", q, e);
        rd_chk("hs_level", 8'h03);
        bus(8'h02, 1'b0, 8'h00, q); chk("hs_empty_d1", q, 8'h00);
        rd_chk("hs_empty_d0", 8'h01);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 10))
                0, 1, 2, 3: send(8'($urandom));
                4:       rd_chk("rnd_d0", 8'h01);
                5, 6:    rd_chk("rnd_d1", 8'h02);
                7:       rd_chk("rnd_level", 8'h03);
                8:       rd_chk("rnd_ctrl", 8'h00);
                9: begin
                    d = 8'($urandom) & 8'h17;
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    wr(8'h00, d);
                end
                default: begin
                    b = 8'($urandom_range(4, 255));
                    wr(b, 8'($urandom));
                    rd_chk("rnd_other", b);
                end
            endcase
            int_chk("rnd_int");
        end

        // Reset in the middle of an acknowledged read
        wr(8'h00, 8'h03);
        send(8'hA5); send(8'h5A);
        addr = 8'h01; write = 1'b0; valid = 1'b1;
        for (int k = 0; k < 10 && !ready; k++) begin
            @(posedge SYS_CLK); #1;
        end
        chk("rst_pre_ready", ready, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_dout", Data_out, 8'h00);
        chk("rst_int", RX_INT, 1'b0);
        valid = 1'b0;
        m_reset();
        @(negedge SYS_CLK);
        @(negedge SYS_CLK); RST_N = 1'b1;
        @(posedge SYS_CLK); #1;
        rd_chk("rst_level", 8'h03);
        rd_chk("rst_ctrl", 8'h00);
        wr(8'h00, 8'h03);
        send(8'h12); send(8'h34);
        rd_chk("rst_post_d0", 8'h01);
        rd_chk("rst_post_d1", 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
